// File: rtl/sar_pkg.sv
// Shared constants and state encoding for the SAR capture controller.
package sar_pkg;

    localparam int SAR_W          = 8;
    localparam int SAR_MIN_PERIOD = 20;
    localparam int SAR_ACC_W      = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sar_state_e;

endpackage

// File: rtl/sar_fifo.sv
// Synchronous show-ahead FIFO; rd_data is the head entry, forced to 0 when empty.
module sar_fifo
    import sar_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = SAR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wr_data,
    output logic [W-1:0]           rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sar_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // alongside a pop still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sar_capture_ctrl.sv
// SAR conversion sequencer, eoc arming and result buffer.
// Optional 4-sample averaging is enabled by defining SAR_AVG_EN.
module sar_capture_ctrl
    import sar_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PERIOD = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   sar_eoc,
    input  logic [SAR_W-1:0]       sar_data,
    output logic                   sar_start,
    input  logic                   rd_en,
    output logic [SAR_W-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   err_late,
    input  logic                   clr_err
);

    localparam int CNT_W = $clog2(PERIOD);

    if (PERIOD < SAR_MIN_PERIOD) begin : g_bad_period
        $error("sar_capture_ctrl: PERIOD below SAR_MIN_PERIOD");
    end

    sar_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             start_next;
    logic             armed, armed_next;
    logic             accept;
    logic             late;
    logic             leave_run;
    logic             push;
    logic [SAR_W-1:0] push_data;
    logic             ovf_set;

    assign accept    = (state == RUN) && sar_eoc && armed;
    assign late      = sar_start && armed && !accept;
    assign leave_run = (state == RUN) && !en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sar_start <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            sar_start <= start_next;
            armed     <= armed_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start_next = 1'b0;
        armed_next = armed;
        // Accept before re-arm: a start in the same cycle opens a fresh slot.
        if (accept)    armed_next = 1'b0;
        if (sar_start) armed_next = 1'b1;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                    start_next = 1'b1;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    armed_next = 1'b0;
                end else if (cnt == CNT_W'(PERIOD - 1)) begin
                    cnt_next   = '0;
                    start_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SAR_AVG_EN
    logic [SAR_ACC_W-1:0] acc;
    logic [1:0]           phase;
    logic [SAR_ACC_W-1:0] sum;

    assign sum       = acc + SAR_ACC_W'(sar_data);
    assign push      = accept && (phase == 2'd3);
    assign push_data = SAR_W'(sum >> 2);

    always_ff @(posedge clk) begin
        if (reset || leave_run) begin
            acc   <= '0;
            phase <= '0;
        end else if (accept) begin
            if (phase == 2'd3) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + 1'b1;
            end
        end
    end
`else
    assign push      = accept;
    assign push_data = sar_data;
`endif

    // When full, a pop makes room, so only a push without rd_en is lost.
    assign ovf_set = push && full && !rd_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            err_late <= 1'b0;
        end else begin
            overflow <= ovf_set || (overflow && !clr_err);
            err_late <= late    || (err_late && !clr_err);
        end
    end

    sar_fifo #(
        .DEPTH (DEPTH),
        .W     (SAR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (rd_en),
        .wr_data (push_data),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_sar_capture_ctrl.sv
// Scoreboard bench for sar_capture_ctrl with a behavioural SAR and capture model.
module tb_sar_capture_ctrl;

    localparam int DEPTH  = 16;
    localparam int PERIOD = 40;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   en = 1'b0;
    logic                   sar_eoc = 1'b0;
    logic [7:0]             sar_data = 8'h00;
    logic                   sar_start;
    logic                   rd_en = 1'b0;
    logic [7:0]             rd_data;
    logic                   empty;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   err_late;
    logic                   clr_err = 1'b0;

    always #5 clk = ~clk;

    sar_capture_ctrl #(.DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
        .clk(clk), .reset(reset), .en(en), .sar_eoc(sar_eoc), .sar_data(sar_data),
        .sar_start(sar_start), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
        .full(full), .count(count), .overflow(overflow), .err_late(err_late),
        .clr_err(clr_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp, input int c);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, c);
        end
    endtask

    // Reference model: conversion windows, an ordered list of buffered results
    int          cyc = 0;
    bit          m_run = 0;
    int          t0 = 0;
    bit          m_open = 0;
    int          m_cnt = 0;
    bit          m_ovf = 0;
    bit          m_late = 0;
    byte unsigned exp_q[$];
    int          avg_q[$];

    // Stimulus controls
    bit          rst_cmd = 1;
    bit          en_cmd = 0;
    bit          clr_cmd = 0;
    int          rd_mode = 0;      // 0 none, 1 always, 2 random, 3 on real eoc
    int          fixed_delay = 18; // 0 = random
    int          spur_n = 0;
    bit          free_run = 0;
    bit          rnd_ctrl = 0;
    int          fix_val = -1;
    byte unsigned data_list[$];

    // SAR model: a start (re)launches a conversion, aborting any pending one
    bit          sar_busy = 0;
    bit          sar_real = 0;
    int          sar_due = 0;
    byte unsigned sar_val = 0;

    function automatic byte unsigned next_val();
        if (data_list.size() > 0) return data_list.pop_front();
        if (fix_val >= 0) return 8'(fix_val);
        return 8'($urandom);
    endfunction

    function automatic int next_delay();
        if (fixed_delay > 0) return fixed_delay;
        if ($urandom_range(0, 3) == 0) return PERIOD;
        return int'($urandom_range(2, 38));
    endfunction

    task automatic model_reset();
        m_run = 0; m_open = 0; m_cnt = 0; m_ovf = 0; m_late = 0;
        exp_q.delete();
        avg_q.delete();
    endtask

    task automatic cycle();
        bit exp_start, eoc_v, real_v, rd_v, clr_v, acc, late, pushv, pop, ovf_set, leave;
        byte unsigned data_v, v;
        int sum;
        @(posedge clk);
        #1;
        cyc++;
        exp_start = m_run && (cyc >= t0) && (((cyc - t0) % PERIOD) == 0);
        chk("sar_start", int'(sar_start), int'(exp_start), cyc);
        chk("count", int'(count), m_cnt, cyc);
        chk("empty", int'(empty), int'(m_cnt == 0), cyc);
        chk("full", int'(full), int'(m_cnt == DEPTH), cyc);
        chk("overflow", int'(overflow), int'(m_ovf), cyc);
        chk("err_late", int'(err_late), int'(m_late), cyc);
        if (m_cnt == 0) chk("rd_data_empty", int'(rd_data), 0, cyc);

        eoc_v = 0; real_v = 0; data_v = 8'($urandom);
        if (sar_busy && cyc == sar_due) begin
            eoc_v = 1; data_v = sar_val; real_v = sar_real; sar_busy = 0;
            if (free_run && real_v) begin
                sar_busy = 1; sar_real = 0; sar_due = cyc + 10; sar_val = 8'($urandom);
            end
        end else if (spur_n != 0 && $urandom_range(0, spur_n - 1) == 0) begin
            eoc_v = 1;
        end
        if (sar_start) begin
            sar_busy = 1; sar_real = 1; sar_due = cyc + next_delay(); sar_val = next_val();
        end

        if (rnd_ctrl && $urandom_range(0, 199) == 0) en_cmd = !en_cmd;
        case (rd_mode)
            1: rd_v = 1;
            2: rd_v = ($urandom_range(0, 2) == 0);
            3: rd_v = real_v;
            default: rd_v = 0;
        endcase
        clr_v = clr_cmd || (rnd_ctrl && $urandom_range(0, 39) == 0);

        reset = rst_cmd; en = en_cmd; sar_eoc = eoc_v; sar_data = data_v;
        rd_en = rd_v; clr_err = clr_v;

        if (rst_cmd) begin
            model_reset();
        end else begin
            acc   = m_run && eoc_v && m_open;
            late  = exp_start && m_open && !acc;
            leave = m_run && !en_cmd;
            pushv = 0; v = 0;
            if (acc) begin
`ifdef SAR_AVG_EN
                avg_q.push_back(int'(data_v));
                if (avg_q.size() == 4) begin
                    sum = avg_q.sum();
                    v = 8'(sum / 4);
                    pushv = 1;
                    avg_q.delete();
                end
`else
                v = data_v;
                pushv = 1;
`endif
            end
            pop = rd_v && (m_cnt > 0);
            ovf_set = 0;
            if (pushv) begin
                if (m_cnt < DEPTH || pop) begin
                    exp_q.push_back(v);
                    m_cnt++;
                end else begin
                    ovf_set = 1;
                end
            end
            if (pop) m_cnt--;
            m_ovf  = ovf_set || (m_ovf && !clr_v);
            m_late = late || (m_late && !clr_v);
            if (leave) m_open = 0;
            else if (exp_start) m_open = 1;
            else if (acc) m_open = 0;
            if (leave) begin
                m_run = 0;
                avg_q.delete();
            end else if (!m_run && en_cmd) begin
                m_run = 1;
                t0 = cyc + 1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        en_cmd = 0; rd_mode = 1;
        run(DEPTH + 4);
        rd_mode = 0;
    endtask

    // Monitor: every pop the DUT performs must match the scoreboard head
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_pop: DUT popped 0x%0h, scoreboard empty (cycle %0d)", rd_data, cyc);
            end else begin
                chk("rd_pop", int'(rd_data), int'(exp_q.pop_front()), cyc);
            end
        end
    end

    initial begin
        // Reset
        run(2);
        rst_cmd = 0;
        run(2);

        // Basic capture: fixed 8'hA5, 18-cycle SAR
        fix_val = 8'hA5; fixed_delay = 18; en_cmd = 1;
        run(170);
        chk("basic_count", int'(count), 4, cyc);
        chk("basic_data", int'(rd_data), 8'hA5, cyc);
        chk("basic_late", int'(err_late), 0, cyc);
        en_cmd = 0;
        run(30);
        chk("eoc_after_disable", int'(count), 4, cyc);

        // Unarmed free-run restarts between starts
        fix_val = -1; free_run = 1; en_cmd = 1;
        run(2 * PERIOD + 1);
        chk("unarmed_count", int'(count), 6, cyc);
        drain();

        // Late conversion: SAR slower than the sample period
        fixed_delay = 45; free_run = 0; en_cmd = 1;
        run(95);
        chk("late_flag", int'(err_late), 1, cyc);
        chk("late_count", int'(count), 0, cyc);
        en_cmd = 0;
        run(5);
        clr_cmd = 1;
        run(1);
        clr_cmd = 0;
        run(2);
        chk("late_clear", int'(err_late), 0, cyc);

        // Fill and overflow, then full push with simultaneous pop
        fixed_delay = 18; free_run = 1; en_cmd = 1;
        run(16 * PERIOD + 25);
        chk("fill_full", int'(full), 1, cyc);
        chk("fill_count", int'(count), DEPTH, cyc);
        chk("fill_ovf", int'(overflow), 1, cyc);
        clr_cmd = 1;
        run(1);
        clr_cmd = 0;
        rd_mode = 3;
        run(PERIOD);
        chk("fullpop_count", int'(count), DEPTH, cyc);
        chk("fullpop_ovf", int'(overflow), 0, cyc);
        drain();

        // Averaging pattern
        data_list = '{8'h10, 8'h20, 8'h30, 8'h41};
        free_run = 0; en_cmd = 1;
        run(4 * PERIOD + 5);
        en_cmd = 0;
        run(2);
`ifdef SAR_AVG_EN
        chk("avg_count", int'(count), 1, cyc);
        chk("avg_data", int'(rd_data), 8'h28, cyc);
`else
        chk("avg_count", int'(count), 4, cyc);
        chk("avg_data", int'(rd_data), 8'h10, cyc);
`endif
        drain();

        // Randomized operation
        fixed_delay = 0; free_run = 1; spur_n = 50; rd_mode = 2; rnd_ctrl = 1; en_cmd = 1;
        run(1500);
        rnd_ctrl = 0; spur_n = 0; clr_cmd = 1;
        drain();
        clr_cmd = 0;

        // Drop en mid-conversion, then reset mid-run
        fixed_delay = 18; free_run = 0; en_cmd = 1;
        run(90);
        en_cmd = 0;
        run(20);
        chk("drop_count", int'(count), 2, cyc);
        en_cmd = 1;
        run(10);
        en_cmd = 0; rst_cmd = 1;
        run(1);
        rst_cmd = 0;
        run(15);
        chk("rst_count", int'(count), 0, cyc);
        chk("rst_empty", int'(empty), 1, cyc);
        chk("rst_full", int'(full), 0, cyc);
        chk("rst_rd_data", int'(rd_data), 0, cyc);
        chk("rst_start", int'(sar_start), 0, cyc);
        chk("rst_flags", int'({overflow, err_late}), 0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
